// File: rtl/wb_write_buffer_pkg.sv
// Common types for the writeback buffer: one queued register write.
`include "defines.vh"
package wb_write_buffer_pkg;
   localparam int REG_ADDR_W = `REG_ADDR_W;
   localparam int DATA_W     = `DATA_W;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [DATA_W-1:0]     data;
   } wb_entry_t;
endpackage

// File: rtl/defines.vh
// Shared widths for the writeback path and a pointer-width helper.
`ifndef WB_DEFINES_VH
`define WB_DEFINES_VH
`define REG_ADDR_W 5
`define DATA_W 32
`define WB_PTR_W(depth) $clog2(depth)
`endif

// File: rtl/wb_mpmp_fifo.sv
// Multi-push / multi-pop circular buffer; pushes arrive compacted in slots 0..push_cnt-1.
`include "defines.vh"
module wb_mpmp_fifo
   import wb_write_buffer_pkg::*;
#(
   parameter int PUSH_N = 2,
   parameter int DEPTH  = 4,
   localparam int PW    = `WB_PTR_W(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [CW-1:0] push_cnt,
   input  wb_entry_t     push_data [PUSH_N],
   input  logic [CW-1:0] pop_cnt,
   output wb_entry_t     mem [DEPTH],
   output logic [PW-1:0] head,
   output logic [CW-1:0] count
);
   logic [PW-1:0] tail;

   // Pointer arithmetic truncates to PW bits, which is the modulo-DEPTH wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + pop_cnt[PW-1:0];
         tail  <= tail + push_cnt[PW-1:0];
         count <= count - pop_cnt + push_cnt;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < PUSH_N; i++) begin
         if (CW'(i) < push_cnt) mem[tail + PW'(i)] <= push_data[i];
      end
   end
endmodule

// File: rtl/wb_write_buffer.sv
// Writeback stage: compacts retiring lanes into an in-order buffer and drains to REGFILE.
// Optional build macro WB_FWD_EN adds a combinational lookup of pending writes.
`include "defines.vh"
module wb_write_buffer
   import wb_write_buffer_pkg::*;
#(
   parameter int NUM_LANES    = 2,
   parameter int NUM_WR_PORTS = 1,
   parameter int BUF_DEPTH    = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               stall,
   input  logic                               flush,
   input  logic [NUM_LANES-1:0]               reg_wr,
   input  logic [NUM_LANES*`REG_ADDR_W-1:0]   reg_addr_rd,
   input  logic [NUM_LANES*`DATA_W-1:0]       reg_data_rd,
   output logic                               wb_full,
   output logic [NUM_WR_PORTS-1:0]            regfile_wr,
   output logic [NUM_WR_PORTS*`REG_ADDR_W-1:0] regfile_addr_wr,
   output logic [NUM_WR_PORTS*`DATA_W-1:0]    regfile_data_wr
`ifdef WB_FWD_EN
   ,
   input  logic [`REG_ADDR_W-1:0]             fwd_addr,
   output logic                               fwd_hit,
   output logic [`DATA_W-1:0]                 fwd_data
`endif
);
   localparam int AW = REG_ADDR_W;
   localparam int DW = DATA_W;
   localparam int PW = `WB_PTR_W(BUF_DEPTH);
   localparam int CW = PW + 1;
   localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

   wb_entry_t                push_data [NUM_LANES];
   wb_entry_t                mem [BUF_DEPTH];
   wb_entry_t                port_e [NUM_WR_PORTS];
   logic [NUM_WR_PORTS-1:0]  port_valid;
   logic [PW-1:0]            head;
   logic [CW-1:0]            count;
   logic [CW-1:0]            push_cnt;
   logic [CW-1:0]            pop_cnt;
   logic                     accept;
   logic [LW-1:0]            slot;
   logic [CW-1:0]            lane_cnt;

   // Registered count only, so a full lane group always fits.
   assign wb_full = (CW'(BUF_DEPTH) - count) < CW'(NUM_LANES);
   assign accept  = !stall && !flush && !wb_full;
   assign pop_cnt = (count < CW'(NUM_WR_PORTS)) ? count : CW'(NUM_WR_PORTS);

   always_comb begin
      slot     = '0;
      lane_cnt = '0;
      for (int i = 0; i < NUM_LANES; i++) push_data[i] = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (reg_wr[i]) begin
            push_data[slot] = '{addr: reg_addr_rd[i*AW +: AW], data: reg_data_rd[i*DW +: DW]};
            slot     = slot + 1'b1;
            lane_cnt = lane_cnt + 1'b1;
         end
      end
      push_cnt = accept ? lane_cnt : '0;
   end

   // An older drained write is suppressed when a younger one in the same cycle hits its address.
   always_comb begin
      regfile_wr      = '0;
      regfile_addr_wr = '0;
      regfile_data_wr = '0;
      for (int j = 0; j < NUM_WR_PORTS; j++) begin
         port_e[j]     = mem[head + PW'(j)];
         port_valid[j] = CW'(j) < pop_cnt;
      end
      for (int j = 0; j < NUM_WR_PORTS; j++) begin
         regfile_addr_wr[j*AW +: AW] = port_e[j].addr;
         regfile_data_wr[j*DW +: DW] = port_e[j].data;
         regfile_wr[j]               = port_valid[j];
         for (int k = j + 1; k < NUM_WR_PORTS; k++) begin
            if (port_valid[k] && (port_e[k].addr == port_e[j].addr)) regfile_wr[j] = 1'b0;
         end
      end
   end

`ifdef WB_FWD_EN
   // Scan oldest to youngest so the last match wins.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int a = 0; a < BUF_DEPTH; a++) begin
         if ((CW'(a) < count) && (mem[head + PW'(a)].addr == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = mem[head + PW'(a)].data;
         end
      end
   end
`endif

   wb_mpmp_fifo #(
      .PUSH_N (NUM_LANES),
      .DEPTH  (BUF_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_cnt  (push_cnt),
      .push_data (push_data),
      .pop_cnt   (pop_cnt),
      .mem       (mem),
      .head      (head),
      .count     (count)
   );
endmodule

// File: tb/tb_wb_write_buffer.sv
// Scoreboard bench for wb_write_buffer: one-port (a_) and two-port (b_) instances.
`include "defines.vh"
module tb_wb_write_buffer;
   localparam int AW = `REG_ADDR_W;
   localparam int DW = `DATA_W;
   localparam int EW = AW + DW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [EW-1:0] exp_a_q[$];
   logic [EW-1:0] exp_b_q[$];

   logic            a_stall, a_flush, a_full;
   logic [1:0]      a_reg_wr;
   logic [2*AW-1:0] a_addr;
   logic [2*DW-1:0] a_data;
   logic [0:0]      a_rf_wr;
   logic [AW-1:0]   a_rf_addr;
   logic [DW-1:0]   a_rf_data;

   logic            b_stall, b_flush, b_full;
   logic [1:0]      b_reg_wr;
   logic [2*AW-1:0] b_addr;
   logic [2*DW-1:0] b_data;
   logic [1:0]      b_rf_wr;
   logic [2*AW-1:0] b_rf_addr;
   logic [2*DW-1:0] b_rf_data;

`ifdef WB_FWD_EN
   logic [AW-1:0] a_fwd_addr, b_fwd_addr;
   logic          a_fwd_hit, b_fwd_hit;
   logic [DW-1:0] a_fwd_data, b_fwd_data;
`endif

   wb_write_buffer #(.NUM_LANES(2), .NUM_WR_PORTS(1), .BUF_DEPTH(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .stall(a_stall), .flush(a_flush),
      .reg_wr(a_reg_wr), .reg_addr_rd(a_addr), .reg_data_rd(a_data),
      .wb_full(a_full), .regfile_wr(a_rf_wr),
      .regfile_addr_wr(a_rf_addr), .regfile_data_wr(a_rf_data)
`ifdef WB_FWD_EN
      , .fwd_addr(a_fwd_addr), .fwd_hit(a_fwd_hit), .fwd_data(a_fwd_data)
`endif
   );

   wb_write_buffer #(.NUM_LANES(2), .NUM_WR_PORTS(2), .BUF_DEPTH(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .stall(b_stall), .flush(b_flush),
      .reg_wr(b_reg_wr), .reg_addr_rd(b_addr), .reg_data_rd(b_data),
      .wb_full(b_full), .regfile_wr(b_rf_wr),
      .regfile_addr_wr(b_rf_addr), .regfile_data_wr(b_rf_data)
`ifdef WB_FWD_EN
      , .fwd_addr(b_fwd_addr), .fwd_hit(b_fwd_hit), .fwd_data(b_fwd_data)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitors: every presented regfile write is matched against the expected queue.
   always @(negedge clk) begin
      if (rst_n && a_rf_wr[0]) begin
         if (exp_a_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL a_port0: got write addr=%0d data=%h, expected none", a_rf_addr, a_rf_data);
         end else begin
            check("a_port0", 64'({a_rf_addr, a_rf_data}), 64'(exp_a_q.pop_front()));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         for (int j = 0; j < 2; j++) begin
            if (b_rf_wr[j]) begin
               if (exp_b_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL b_port%0d: got write addr=%0d data=%h, expected none",
                           j, b_rf_addr[j*AW +: AW], b_rf_data[j*DW +: DW]);
               end else begin
                  check($sformatf("b_port%0d", j),
                        64'({b_rf_addr[j*AW +: AW], b_rf_data[j*DW +: DW]}),
                        64'(exp_b_q.pop_front()));
               end
            end
         end
      end
   end

   // Driver for dut_a: waits out back-pressure, then models in-order lane compaction.
   task automatic a_push(input logic [1:0] wr, input logic [AW-1:0] ad0, input logic [DW-1:0] d0,
                         input logic [AW-1:0] ad1, input logic [DW-1:0] d1);
      int n = 0;
      a_reg_wr = wr;
      a_addr   = {ad1, ad0};
      a_data   = {d1, d0};
      while (a_full && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (a_full) begin
         checks++;
         errors++;
         $display("FAIL a_push_timeout: got wb_full=1 after %0d cycles, expected 0", n);
      end
      if (wr[0]) exp_a_q.push_back({ad0, d0});
      if (wr[1]) exp_a_q.push_back({ad1, d1});
      @(posedge clk); #1;
      a_reg_wr = '0;
   endtask

   task automatic b_drive(input logic [1:0] wr, input logic [AW-1:0] ad0, input logic [DW-1:0] d0,
                          input logic [AW-1:0] ad1, input logic [DW-1:0] d1);
      b_reg_wr = wr;
      b_addr   = {ad1, ad0};
      b_data   = {d1, d0};
      @(posedge clk); #1;
      b_reg_wr = '0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_a_q.size() != 0 || exp_b_q.size() != 0) && n < 100) begin
         @(posedge clk);
         n++;
      end
      if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d/%0d pending, expected 0/0", exp_a_q.size(), exp_b_q.size());
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000, expected finish");
      $fatal(1);
   end

   initial begin
      a_stall = 0; a_flush = 0; a_reg_wr = '0; a_addr = '0; a_data = '0;
      b_stall = 0; b_flush = 0; b_reg_wr = '0; b_addr = '0; b_data = '0;
`ifdef WB_FWD_EN
      a_fwd_addr = '0;
      b_fwd_addr = '0;
`endif
      repeat (2) @(posedge clk);
      #1;
      check("reset_a_rf_wr", 64'(a_rf_wr), 64'(0));
      check("reset_a_full", 64'(a_full), 64'(0));
      check("reset_b_rf_wr", 64'(b_rf_wr), 64'(0));
      check("reset_b_full", 64'(b_full), 64'(0));
`ifdef WB_FWD_EN
      check("reset_a_fwd_hit", 64'(a_fwd_hit), 64'(0));
`endif
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Two lanes, one port: addr 3 then addr 5.
      a_push(2'b11, 5'd3, 32'hA, 5'd5, 32'hB);
      check("two_lane_not_full", 64'(a_full), 64'(0));
      wait_idle();

      // Only lane 1 valid: no hole left by lane 0.
      a_push(2'b10, 5'd0, 32'h0, 5'd7, 32'h77);
      check("one_lane_not_full", 64'(a_full), 64'(0));
      wait_idle();

      // Three back-to-back groups: third must wait for headroom.
      a_push(2'b11, 5'd1, 32'h11, 5'd2, 32'h12);
      a_push(2'b11, 5'd3, 32'h13, 5'd4, 32'h14);
      check("full_at_count3", 64'(a_full), 64'(1));
      a_push(2'b11, 5'd5, 32'h15, 5'd6, 32'h16);
      wait_idle();
      check("full_clears", 64'(a_full), 64'(0));

      // Flush then stall with lanes active: nothing pushed, pending entries still drain.
      a_push(2'b11, 5'd1, 32'h101, 5'd2, 32'h102);
      a_reg_wr = 2'b11; a_addr = {5'd21, 5'd20}; a_data = {32'hDEAD, 32'hBEEF};
      a_flush = 1'b1;
      @(posedge clk); #1;
      a_flush = 1'b0;
      a_stall = 1'b1;
      @(posedge clk); #1;
      a_stall = 1'b0;
      a_reg_wr = '0;
      check("flush_stall_empty_full", 64'(a_full), 64'(0));
      wait_idle();

      // Two ports, same address drained together: only the younger writes.
      exp_b_q.push_back({5'd4, 32'h2});
      b_drive(2'b11, 5'd4, 32'h1, 5'd4, 32'h2);
      @(negedge clk);
      check("b_conflict_mask", 64'(b_rf_wr), 64'(2'b10));
      wait_idle();

      // Two ports, distinct addresses, then a single straggler.
      exp_b_q.push_back({5'd1, 32'h11});
      exp_b_q.push_back({5'd2, 32'h22});
      exp_b_q.push_back({5'd3, 32'h33});
      b_drive(2'b11, 5'd1, 32'h11, 5'd2, 32'h22);
      b_drive(2'b01, 5'd3, 32'h33, 5'd0, 32'h0);
      @(negedge clk);
      check("b_single_pop", 64'(b_rf_wr), 64'(2'b01));
      wait_idle();

`ifdef WB_FWD_EN
      a_fwd_addr = 5'd9;
      a_push(2'b11, 5'd9, 32'h10, 5'd9, 32'h20);
      check("fwd_hit", 64'(a_fwd_hit), 64'(1));
      check("fwd_youngest", 64'(a_fwd_data), 64'(32'h20));
      wait_idle();
      check("fwd_miss_empty", 64'(a_fwd_hit), 64'(0));
      a_fwd_addr = 5'd3;
`endif

      // Reset with entries pending: discarded, no writes afterwards.
      a_push(2'b11, 5'd1, 32'h21, 5'd2, 32'h22);
      a_push(2'b11, 5'd3, 32'h23, 5'd4, 32'h24);
      check("pre_reset_full", 64'(a_full), 64'(1));
      rst_n = 1'b0;
      #1;
      check("mid_reset_rf_wr", 64'(a_rf_wr), 64'(0));
      check("mid_reset_full", 64'(a_full), 64'(0));
`ifdef WB_FWD_EN
      check("mid_reset_fwd_hit", 64'(a_fwd_hit), 64'(0));
`endif
      exp_a_q.delete();
      exp_b_q.delete();
      @(negedge clk) rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("post_reset_full", 64'(a_full), 64'(0));

      check("a_queue_empty", 64'(exp_a_q.size()), 64'(0));
      check("b_queue_empty", 64'(exp_b_q.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
